weight_rom_arbiter: RTL
=======================

Name: weight_rom_arbiter

Overview:
- Round-robin scheduler that shares one synchronous read-only weight memory between NUM_REQ processing-element requesters.
- Each requester asks for a burst: start address plus length. The block drives the memory enable and address, then tags each returned word with the owning requester ID and an end-of-burst flag.
- Sits between the weight ROM and the PE array loaders.

Parameters:
- NUM_REQ, 4, number of requesters (at least 2).
- ID_BITWIDTH, 2, requester ID width; equals clog2(NUM_REQ).
- DATA_BITWIDTH, 8, memory word width.
- ADDR_BITWIDTH, 4, memory address width; memory depth is 2^ADDR_BITWIDTH.
- LEN_BITWIDTH, 4, burst length field width; the field encodes words-1.
- ROM_LATENCY, 1, cycles from enable/address to valid data at rom_dout (at least 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester burst request, level.
- req_addr  in  NUM_REQ*ADDR_BITWIDTH  start addresses; requester i at [i*ADDR_BITWIDTH +: ADDR_BITWIDTH].
- req_len  in  NUM_REQ*LEN_BITWIDTH  burst length minus 1; requester i at [i*LEN_BITWIDTH +: LEN_BITWIDTH].
- gnt  out  NUM_REQ  one-hot grant pulse, one cycle.
- rom_en  out  1  memory read enable.
- rom_addr  out  ADDR_BITWIDTH  memory read address.
- rom_dout  in  DATA_BITWIDTH  memory read data.
- rd_valid  out  1  returned word valid.
- rd_data  out  DATA_BITWIDTH  returned word.
- rd_id  out  ID_BITWIDTH  owner of the returned word.
- rd_last  out  1  final word of the burst.
- busy  out  1  high while in READ or while any read is still in flight.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; gnt, rom_en, rom_addr, rd_valid, rd_id, rd_last = 0.
  - Return pipeline cleared; rr pointer last_id = NUM_REQ-1, so requester 0 has top priority.
  - Reset mid-burst abandons the burst. No rd_valid for words already issued.
- FSM states: IDLE and READ.
- IDLE:
  - On a clock edge with any req bit high, the winner is the first requester with req set, searching from (last_id+1) mod NUM_REQ upward with wrap.
  - The same edge latches the winner ID, address and length, moves to READ, and registers rom_en=1, rom_addr=req_addr[winner] and gnt=one-hot(winner).
  - Also on that edge, last_id becomes the winner.
- gnt stays high only during the first READ cycle. The requester must drop req by the next arbitration, otherwise it is re-served.
- READ:
  - rom_en stays high.
  - Each edge increments rom_addr modulo 2^ADDR_BITWIDTH (wraps 15→0 at default) and decrements the remaining count.
  - When the last address (len+1 total) has been held for one cycle, the next edge sets rom_en=0 and returns to IDLE.
  - req changes during READ are ignored.
- Back-to-back bursts: exactly one idle cycle (rom_en=0) between the last address of one burst and the first address of the next.
- Return path: a ROM_LATENCY-deep shift register carries {valid, id, last} alongside each issued address.
  - rd_valid, rd_id and rd_last emerge exactly ROM_LATENCY cycles after the matching rom_en cycle.
  - rd_data = rom_dout when rd_valid=1, else 0.
  - A burst of N words yields N consecutive rd_valid cycles; rd_last is high only on the Nth.
- len=0 gives a single-word burst: one rom_en cycle; rd_valid and rd_last high together.
- busy = (state==READ) OR any valid bit in the return pipeline.
- No backpressure: consumers must accept rd_valid every cycle.

Test Plan:
Bench defaults: NUM_REQ=4, ADDR_BITWIDTH=4, ROM_LATENCY=1; the bench memory model returns mem[a]=0x10+a one cycle after an enable at address a.

1. req=0010, addr1=3, len1=2 → gnt=0010 for one cycle; rom_addr 3,4,5 with rom_en high 3 cycles; rd_data 0x13,0x14,0x15 one cycle later; rd_id=1; rd_last on 0x15 only; busy falls after the last rd_valid.
2. Wrap: req=0001, addr0=14, len0=3 → rom_addr 14,15,0,1; rd_data 0x1E,0x1F,0x10,0x11.
3. Round robin: req=0101 held, each len=0 → grant order 0,2,0,2; req[3] raised during requester 2's burst → order continues 3,0,2.
4. Back-to-back: req=0011 held, len=1 each → rom_en pattern 1,1,0,1,1; rd_id 0,0,1,1 across consecutive rd_valid cycles with a one-cycle gap.
5. Single word: addr=7, len=0 → one rom_en cycle; rd_valid=rd_last=1 with rd_data 0x17.
6. Reset mid-burst: rst asserted during the 2nd address of a 4-word burst → rom_en, gnt, rd_valid, busy go 0 without waiting for an edge. After release, with req=1111, the first grant is 0001.

Source files
------------

// File: rtl/weight_rom_arbiter.sv
// weight_rom_arbiter
// Round-robin scheduler sharing one synchronous weight ROM between NUM_REQ
// processing-element loaders. A requester presents a burst (start address,
// length-1); the winner gets a one-cycle grant pulse, the block streams the
// burst addresses to the ROM and tags every returned word with the owner ID
// and an end-of-burst marker.
//
// Handshake semantics:
//   req[i]  is a level request. The one-cycle gnt[i] pulse is the acceptance of
//           the burst described by req_addr/req_len at that edge. A requester
//           still holding req at the next arbitration is served again.
//   rd_valid has no ready: the consumer must take every word on the cycle it is
//           presented (no backpressure).

module weight_rom_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ID_BITWIDTH   = 2,
    parameter int DATA_BITWIDTH = 8,
    parameter int ADDR_BITWIDTH = 4,
    parameter int LEN_BITWIDTH  = 4,
    parameter int ROM_LATENCY   = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*ADDR_BITWIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*LEN_BITWIDTH-1:0]   req_len,
    output logic [NUM_REQ-1:0]                gnt,
    output logic                              rom_en,
    output logic [ADDR_BITWIDTH-1:0]          rom_addr,
    input  logic [DATA_BITWIDTH-1:0]          rom_dout,
    output logic                              rd_valid,
    output logic [DATA_BITWIDTH-1:0]          rd_data,
    output logic [ID_BITWIDTH-1:0]            rd_id,
    output logic                              rd_last,
    output logic                              busy,
    output logic [0:0]                        state_dbg
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] READ = 1'b1;

    logic [0:0]              state;
    logic [ID_BITWIDTH-1:0]  last_id;
    logic [ID_BITWIDTH-1:0]  cur_id;
    logic [LEN_BITWIDTH-1:0] remain;

    logic                     win_found;
    logic [ID_BITWIDTH-1:0]   win_id;
    logic [ADDR_BITWIDTH-1:0] win_addr;
    logic [LEN_BITWIDTH-1:0]  win_len;
    logic [NUM_REQ-1:0]       win_onehot;

    logic                     issue_last;

    logic [ROM_LATENCY-1:0]   pipe_valid;
    logic [ROM_LATENCY-1:0]   pipe_last;
    logic [ID_BITWIDTH-1:0]   pipe_id [ROM_LATENCY];

    // Pick the first requesting port after last_id, wrapping around.
    always_comb begin
        int cand;
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_id) + k) % NUM_REQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand[ID_BITWIDTH-1:0];
            end
        end
    end

    // Burst descriptor and grant vector of the current winner.
    always_comb begin
        win_addr   = req_addr[int'(win_id)*ADDR_BITWIDTH +: ADDR_BITWIDTH];
        win_len    = req_len[int'(win_id)*LEN_BITWIDTH +: LEN_BITWIDTH];
        win_onehot = '0;
        win_onehot[win_id] = 1'b1;
    end

    // The address currently on rom_addr is the final one of its burst.
    assign issue_last = (remain == '0);

    // Arbitration FSM: grant in IDLE, then walk the burst addresses in READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            cur_id   <= '0;
            remain   <= '0;
            last_id  <= ID_BITWIDTH'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    gnt    <= '0;
                    rom_en <= 1'b0;
                    if (win_found) begin
                        state    <= READ;
                        rom_en   <= 1'b1;
                        rom_addr <= win_addr;
                        gnt      <= win_onehot;
                        cur_id   <= win_id;
                        remain   <= win_len;
                        last_id  <= win_id;
                    end
                end
                READ: begin
                    // Grant is a pulse covering only the first READ cycle.
                    gnt <= '0;
                    if (issue_last) begin
                        // Last address has been held one cycle; the following
                        // IDLE cycle is the mandatory gap between bursts.
                        rom_en <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        rom_addr <= rom_addr + ADDR_BITWIDTH'(1);
                        remain   <= remain - LEN_BITWIDTH'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    gnt    <= '0;
                    rom_en <= 1'b0;
                end
            endcase
        end
    end

    // Return pipeline: carries {valid, id, last} alongside each ROM access so
    // the tag lines up with the data ROM_LATENCY cycles later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_last  <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                pipe_id[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= rom_en;
            pipe_last[0]  <= rom_en & issue_last;
            pipe_id[0]    <= cur_id;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_last[i]  <= pipe_last[i-1];
                pipe_id[i]    <= pipe_id[i-1];
            end
        end
    end

    assign rd_valid  = pipe_valid[ROM_LATENCY-1];
    assign rd_last   = pipe_last[ROM_LATENCY-1];
    assign rd_id     = pipe_id[ROM_LATENCY-1];
    assign rd_data   = rd_valid ? rom_dout : '0;
    assign busy      = (state == READ) | (|pipe_valid);
    assign state_dbg = state;

endmodule
